// File: rtl/win_fetch.sv
// win_fetch: feeds a 3x3 convolver one clamped window per pixel, in raster order, from a read-only SRAM.
// A one-deep address prefetch stage feeds the SRAM; reads are issued only when the output register plus skid can absorb them.
module win_fetch #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sram_csn,
  output logic        sram_wen,
  output logic [19:0] sram_a,
  input  logic [15:0] sram_dout,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic [3:0]  pix_tap,
  output logic        pix_last,
  output logic [8:0]  pix_x,
  output logic [9:0]  pix_y
);

  // state | meaning
  // IDLE  | waiting for start; done pulses here for one cycle at the end of a sweep
  // RUN   | walking windows/taps and issuing SRAM reads
  // DRAIN | final read issued, waiting for the last tap to be accepted

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XMAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        r_state;
  logic          r_busy, r_done, r_more;
  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;
  logic [1:0]    r_cdx, r_cdy;

  logic          r_aval, r_a_last;
  logic [19:0]   r_a;
  logic [3:0]    r_a_tap;
  logic [8:0]    r_a_x;
  logic [9:0]    r_a_y;

  logic          r_ret;
  logic [3:0]    r_ret_tap;
  logic [8:0]    r_ret_x;
  logic [9:0]    r_ret_y;

  logic          r_sv;
  logic [15:0]   r_s_data;
  logic [3:0]    r_s_tap;
  logic [8:0]    r_s_x;
  logic [9:0]    r_s_y;

  logic          r_pv;
  logic [15:0]   r_p_data;
  logic [3:0]    r_p_tap;
  logic [8:0]    r_p_x;
  logic [9:0]    r_p_y;

  logic          w_xfer, w_credit, w_issue, w_load, w_fin, w_last_tap;
  logic [1:0]    w_occ;
  logic [XW-1:0] w_xc;
  logic [YW-1:0] w_yc;
  logic [3:0]    w_tap;
  logic [19:0]   w_addr;

  // Edge replication: offsets that would leave the image stay on the border pixel.
  always_comb begin
    w_xc = r_cx;
    if (r_cdx == 2'd0 && r_cx != '0)
      w_xc = r_cx - XW'(1);
    else if (r_cdx == 2'd2 && r_cx != XMAX)
      w_xc = r_cx + XW'(1);
    w_yc = r_cy;
    if (r_cdy == 2'd0 && r_cy != '0)
      w_yc = r_cy - YW'(1);
    else if (r_cdy == 2'd2 && r_cy != YMAX)
      w_yc = r_cy + YW'(1);
  end

  assign w_tap      = 4'(r_cdy) * 4'd3 + 4'(r_cdx);
  assign w_addr     = 20'({w_yc, w_xc});
  assign w_last_tap = (r_cdx == 2'd2) && (r_cdy == 2'd2) && (r_cx == XMAX) && (r_cy == YMAX);

  // A read landing two edges from now must find room even if nothing else drains.
  assign w_xfer   = r_pv & pix_ready;
  assign w_occ    = {1'b0, r_pv} + {1'b0, r_sv} + {1'b0, r_ret};
  assign w_credit = w_xfer ? (w_occ != 2'd3) : (w_occ <= 2'd1);
  assign w_issue  = r_aval & w_credit;
  assign w_load   = r_more & (~r_aval | w_issue);
  assign w_fin    = w_xfer && (r_state == DRAIN) && (r_p_tap == 4'd8) &&
                    (r_p_x == 9'(XMAX)) && (r_p_y == 10'(YMAX));

  assign busy      = r_busy;
  assign done      = r_done;
  assign sram_csn  = ~w_issue;
  assign sram_wen  = 1'b1;
  assign sram_a    = r_a;
  assign pix_valid = r_pv;
  assign pix_data  = r_p_data;
  assign pix_tap   = r_p_tap;
  assign pix_last  = (r_p_tap == 4'd8);
  assign pix_x     = r_p_x;
  assign pix_y     = r_p_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_more    <= 1'b0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_cdx     <= 2'd0;
      r_cdy     <= 2'd0;
      r_aval    <= 1'b0;
      r_a_last  <= 1'b0;
      r_a       <= '0;
      r_a_tap   <= '0;
      r_a_x     <= '0;
      r_a_y     <= '0;
      r_ret     <= 1'b0;
      r_ret_tap <= '0;
      r_ret_x   <= '0;
      r_ret_y   <= '0;
      r_sv      <= 1'b0;
      r_s_data  <= '0;
      r_s_tap   <= '0;
      r_s_x     <= '0;
      r_s_y     <= '0;
      r_pv      <= 1'b0;
      r_p_data  <= '0;
      r_p_tap   <= '0;
      r_p_x     <= '0;
      r_p_y     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !r_busy) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_more  <= 1'b1;
            r_cx    <= '0;
            r_cy    <= '0;
            r_cdx   <= 2'd0;
            r_cdy   <= 2'd0;
          end else if (r_done) begin
            r_busy <= 1'b0;
          end
        end
        RUN: begin
          if (w_issue && r_a_last)
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_fin) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        r_aval   <= 1'b1;
        r_a      <= w_addr;
        r_a_tap  <= w_tap;
        r_a_x    <= 9'(r_cx);
        r_a_y    <= 10'(r_cy);
        r_a_last <= w_last_tap;
        if (w_last_tap)
          r_more <= 1'b0;
        if (r_cdx != 2'd2) begin
          r_cdx <= r_cdx + 2'd1;
        end else begin
          r_cdx <= 2'd0;
          if (r_cdy != 2'd2) begin
            r_cdy <= r_cdy + 2'd1;
          end else begin
            r_cdy <= 2'd0;
            if (r_cx == XMAX) begin
              r_cx <= '0;
              r_cy <= r_cy + YW'(1);
            end else begin
              r_cx <= r_cx + XW'(1);
            end
          end
        end
      end else if (w_issue) begin
        r_aval <= 1'b0;
      end

      r_ret <= w_issue;
      if (w_issue) begin
        r_ret_tap <= r_a_tap;
        r_ret_x   <= r_a_x;
        r_ret_y   <= r_a_y;
      end

      // Skid content always goes out before newer returned data.
      if (w_xfer || !r_pv) begin
        if (r_sv) begin
          r_pv     <= 1'b1;
          r_p_data <= r_s_data;
          r_p_tap  <= r_s_tap;
          r_p_x    <= r_s_x;
          r_p_y    <= r_s_y;
          if (r_ret) begin
            r_s_data <= sram_dout;
            r_s_tap  <= r_ret_tap;
            r_s_x    <= r_ret_x;
            r_s_y    <= r_ret_y;
          end else begin
            r_sv <= 1'b0;
          end
        end else if (r_ret) begin
          r_pv     <= 1'b1;
          r_p_data <= sram_dout;
          r_p_tap  <= r_ret_tap;
          r_p_x    <= r_ret_x;
          r_p_y    <= r_ret_y;
        end else begin
          r_pv <= 1'b0;
        end
      end else if (r_ret) begin
        r_sv     <= 1'b1;
        r_s_data <= sram_dout;
        r_s_tap  <= r_ret_tap;
        r_s_x    <= r_ret_x;
        r_s_y    <= r_ret_y;
      end
    end
  end

endmodule

// File: tb/tb_win_fetch.sv
// Testbench for win_fetch: 8x4 image for full sweeps, plus a default-size instance for the first window.
module tb_win_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, pix_ready;
  logic        busy, done, sram_csn, sram_wen, pix_valid, pix_last;
  logic [19:0] sram_a;
  logic [15:0] sram_dout, pix_data;
  logic [3:0]  pix_tap;
  logic [8:0]  pix_x;
  logic [9:0]  pix_y;

  logic        b_busy, b_done, b_csn, b_wen, b_valid, b_last;
  logic [19:0] b_a;
  logic [15:0] b_dout, b_data;
  logic [3:0]  b_tap;
  logic [8:0]  b_x;
  logic [9:0]  b_y;

  win_fetch #(.IMG_W(8), .IMG_H(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_a(sram_a), .sram_dout(sram_dout),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_tap(pix_tap),
    .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y));

  win_fetch u_big (
    .clk(clk), .rst(rst), .start(start), .busy(b_busy), .done(b_done),
    .sram_csn(b_csn), .sram_wen(b_wen), .sram_a(b_a), .sram_dout(b_dout),
    .pix_valid(b_valid), .pix_ready(pix_ready), .pix_data(b_data), .pix_tap(b_tap),
    .pix_last(b_last), .pix_x(b_x), .pix_y(b_y));

  // SRAM models: word[a] = a[15:0], data valid one clock after the address is sampled
  always @(posedge clk) if (!sram_csn) sram_dout <= sram_a[15:0];
  always @(posedge clk) if (!b_csn) b_dout <= b_a[15:0];

  typedef struct {
    int idx; int data; int tap; int last; int x; int y;
  } vec_t;

  vec_t vecs[17];
  int   big_exp[9];

  int n_pass = 0, n_chk = 0;
  int n_xfer, n_reads, n_stab_err, n_done, fv_k, done_k, busy_at_done, stall_tap, stall_csn;
  int n_bx = 0;
  int bg_data[9];
  int lg_data[512], lg_tap[512], lg_last[512], lg_x[512], lg_y[512];
  int rf_data[512], rf_tap[512], rf_last[512], rf_x[512], rf_y[512];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int mdl_addr(input int idx);
    int c, t, x, y;
    c = idx / 9; t = idx % 9;
    x = c % 8 + t % 3 - 1;
    y = c / 8 + t / 3 - 1;
    if (x < 0) x = 0;
    if (x > 7) x = 7;
    if (y < 0) y = 0;
    if (y > 3) y = 3;
    return y * 8 + x;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // mode 0: ready=1, 1: random ready, 2: ready low until 20 cycles after first valid
  task automatic run_sweep(input int mode, input int stop_after, input int dbl, input int max_cyc);
    bit prev_stall;
    int sv_d, sv_t, sv_l, sv_x, sv_y;
    n_xfer = 0; n_reads = 0; n_stab_err = 0; n_done = 0; fv_k = -1; done_k = -1;
    busy_at_done = 0; stall_tap = -1; stall_csn = -1; prev_stall = 0;
    sv_d = 0; sv_t = 0; sv_l = 0; sv_x = 0; sv_y = 0;
    for (int i = 0; i < 512; i++) lg_data[i] = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (prev_stall && (int'(pix_data) != sv_d || int'(pix_tap) != sv_t ||
          int'(pix_last) != sv_l || int'(pix_x) != sv_x || int'(pix_y) != sv_y || !pix_valid))
        n_stab_err++;
      if (done) begin
        n_done++;
        if (done_k < 0) begin done_k = k; busy_at_done = int'(busy); end
      end
      if (fv_k < 0 && pix_valid) fv_k = k;
      start = (k == dbl);
      case (mode)
        1:       pix_ready = 1'($urandom_range(0, 1));
        2:       pix_ready = (fv_k >= 0 && k >= fv_k + 20);
        default: pix_ready = 1'b1;
      endcase
      #1;
      if (mode == 2 && fv_k >= 0 && k < fv_k + 20 && !sram_csn) n_reads++;
      if (mode == 2 && fv_k >= 0 && k == fv_k + 19) begin
        stall_tap = int'(pix_tap); stall_csn = int'(sram_csn);
      end
      if (b_valid && pix_ready && n_bx < 9) begin bg_data[n_bx] = int'(b_data); n_bx++; end
      if (pix_valid && pix_ready && n_xfer < 512) begin
        lg_data[n_xfer] = int'(pix_data); lg_tap[n_xfer] = int'(pix_tap);
        lg_last[n_xfer] = int'(pix_last); lg_x[n_xfer] = int'(pix_x); lg_y[n_xfer] = int'(pix_y);
        n_xfer++;
      end
      prev_stall = pix_valid && !pix_ready;
      sv_d = int'(pix_data); sv_t = int'(pix_tap); sv_l = int'(pix_last);
      sv_x = int'(pix_x); sv_y = int'(pix_y);
      if (stop_after > 0 && n_xfer == stop_after) return;
      if (done_k >= 0 && k >= done_k + 5) return;
    end
  endtask

  task automatic cmp_ref(input string name);
    int e = 0;
    for (int i = 0; i < 288; i++)
      if (lg_data[i] != rf_data[i] || lg_tap[i] != rf_tap[i] || lg_last[i] != rf_last[i] ||
          lg_x[i] != rf_x[i] || lg_y[i] != rf_y[i]) e++;
    check(name, e, 0);
  endtask

  initial begin
    int e;
    vecs[0]  = '{0,   0,  0, 0, 0, 0};
    vecs[1]  = '{2,   1,  2, 0, 0, 0};
    vecs[2]  = '{6,   8,  6, 0, 0, 0};
    vecs[3]  = '{8,   9,  8, 1, 0, 0};
    vecs[4]  = '{63,  6,  0, 0, 7, 0};
    vecs[5]  = '{65,  7,  2, 0, 7, 0};
    vecs[6]  = '{71,  15, 8, 1, 7, 0};
    vecs[7]  = '{72,  0,  0, 0, 0, 1};
    vecs[8]  = '{75,  8,  3, 0, 0, 1};
    vecs[9]  = '{80,  17, 8, 1, 0, 1};
    vecs[10] = '{171, 10, 0, 0, 3, 2};
    vecs[11] = '{179, 28, 8, 1, 3, 2};
    vecs[12] = '{279, 22, 0, 0, 7, 3};
    vecs[13] = '{281, 23, 2, 0, 7, 3};
    vecs[14] = '{283, 31, 4, 0, 7, 3};
    vecs[15] = '{285, 30, 6, 0, 7, 3};
    vecs[16] = '{287, 31, 8, 1, 7, 3};
    big_exp = '{0, 0, 1, 0, 0, 1, 512, 512, 513};

    rst = 1'b0; start = 1'b0; pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_csn", int'(sram_csn), 1);
    check("rst_wen", int'(sram_wen), 1);
    check("rst_valid", int'(pix_valid), 0);
    check("rst_addr", int'(sram_a), 0);
    rst = 1'b1;

    // full-throughput sweep
    pulse_start();
    run_sweep(0, 0, -1, 400);
    check("t1_done_seen", int'(done_k >= 0), 1);
    check("t1_xfers", n_xfer, 288);
    check("t1_first_valid_k", fv_k, 3);
    check("t1_done_k", done_k, 291);
    check("t1_done_count", n_done, 1);
    check("t1_busy_at_done", busy_at_done, 1);
    check("t1_busy_after", int'(busy), 0);
    for (int i = 0; i < 17; i++) begin
      check($sformatf("vec%0d_data", vecs[i].idx), lg_data[vecs[i].idx], vecs[i].data);
      check($sformatf("vec%0d_tap", vecs[i].idx), lg_tap[vecs[i].idx], vecs[i].tap);
      check($sformatf("vec%0d_last", vecs[i].idx), lg_last[vecs[i].idx], vecs[i].last);
      check($sformatf("vec%0d_x", vecs[i].idx), lg_x[vecs[i].idx], vecs[i].x);
      check($sformatf("vec%0d_y", vecs[i].idx), lg_y[vecs[i].idx], vecs[i].y);
    end
    e = 0;
    for (int i = 0; i < 288; i++)
      if (lg_data[i] != mdl_addr(i) || lg_tap[i] != i % 9 || lg_last[i] != int'(i % 9 == 8) ||
          lg_x[i] != (i / 9) % 8 || lg_y[i] != (i / 9) / 8) e++;
    check("t1_seq_model", e, 0);
    check("big_taps_seen", n_bx, 9);
    for (int i = 0; i < 9; i++) check($sformatf("big_tap%0d_addr", i), bg_data[i], big_exp[i]);
    for (int i = 0; i < 512; i++) begin
      rf_data[i] = lg_data[i]; rf_tap[i] = lg_tap[i]; rf_last[i] = lg_last[i];
      rf_x[i] = lg_x[i]; rf_y[i] = lg_y[i];
    end

    // random backpressure
    pulse_start();
    run_sweep(1, 0, -1, 3000);
    check("t2_xfers", n_xfer, 288);
    check("t2_done_count", n_done, 1);
    check("t2_stable", n_stab_err, 0);
    cmp_ref("t2_seq");

    // long stall right after first valid
    pulse_start();
    run_sweep(2, 0, -1, 3000);
    check("t3_reads_le2", int'(n_reads <= 2), 1);
    check("t3_csn_idle", stall_csn, 1);
    check("t3_tap_held", stall_tap, 0);
    check("t3_stable", n_stab_err, 0);
    check("t3_xfers", n_xfer, 288);
    cmp_ref("t3_seq");

    // start pulsed mid-sweep must be ignored
    pulse_start();
    run_sweep(0, 0, 50, 400);
    check("t4_done_count", n_done, 1);
    check("t4_xfers", n_xfer, 288);
    cmp_ref("t4_seq");

    // reset at transfer 100, then restart
    pulse_start();
    run_sweep(0, 100, -1, 400);
    check("t5_reached_100", n_xfer, 100);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 0);
    check("t5_csn", int'(sram_csn), 1);
    check("t5_addr", int'(sram_a), 0);
    check("t5_valid", int'(pix_valid), 0);
    check("t5_data", int'(pix_data), 0);
    check("t5_tap", int'(pix_tap), 0);
    check("t5_last", int'(pix_last), 0);
    check("t5_xy", int'(pix_x) + int'(pix_y), 0);
    @(negedge clk); rst = 1'b1;
    pulse_start();
    run_sweep(0, 0, -1, 400);
    check("t5_first_tap", lg_tap[0], 0);
    check("t5_first_xy", lg_x[0] + lg_y[0], 0);
    check("t5_first_data", lg_data[0], 0);
    check("t5_xfers", n_xfer, 288);
    cmp_ref("t5_seq");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
